// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared constants for the forwarding/hazard unit
package fwd_hazard_unit_pkg;

  // Select encodings: 0 means "use the ID/EX register value" (operands)
  // or "no forward" (store data); k means result of entry k-1.
  localparam int FWD_SEL_REG  = 0;
  localparam int FWD_SEL_NONE = 0;

  // Register x0 is hardwired zero and never participates in forwarding.
  localparam int REG_X0 = 0;

  // Default geometry of the entry pipeline and its fields.
  localparam int DEF_NUM_FWD_STAGES = 3;
  localparam int DEF_REG_AW         = 5;
  localparam int DEF_LAT_W          = 2;
  localparam int DEF_CNT_W          = 32;

  // First entry index eligible as a store-data source (entry 0 is the store itself).
  localparam int STORE_SRC_MIN = 1;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - pipeline-side bundle of the forwarding/hazard unit
interface fwd_hazard_unit_if
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int LAT_W  = DEF_LAT_W,
  parameter int SEL_W  = $clog2(DEF_NUM_FWD_STAGES + 1),
  parameter int CNT_W  = DEF_CNT_W
);

  logic              pipe_hold;
  logic              ex_valid;
  logic              ex_regs_write;
  logic [REG_AW-1:0] ex_rd;
  logic [LAT_W-1:0]  ex_lat;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic              me_mem_write;
  logic [REG_AW-1:0] me_rs2;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic [SEL_W-1:0]  fwd_sel_store;
  logic              hazard_stall;
  logic [CNT_W-1:0]  stall_cycles;

  // Pipeline control side: describes the EX/MEM instructions, consumes selects.
  modport master (
    output pipe_hold, ex_valid, ex_regs_write, ex_rd, ex_lat, ex_rs1, ex_rs2,
           me_mem_write, me_rs2,
    input  fwd_sel_a, fwd_sel_b, fwd_sel_store, hazard_stall, stall_cycles
  );

  // Hazard unit side.
  modport slave (
    input  pipe_hold, ex_valid, ex_regs_write, ex_rd, ex_lat, ex_rs1, ex_rs2,
           me_mem_write, me_rs2,
    output fwd_sel_a, fwd_sel_b, fwd_sel_store, hazard_stall, stall_cycles
  );

endinterface

// File: rtl/fwd_hazard_unit_entry_pipe.sv
// rtl/fwd_hazard_unit_entry_pipe.sv - in-flight writer tracking shift pipeline
module fwd_entry_pipe
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_FWD_STAGES = DEF_NUM_FWD_STAGES,
  parameter int REG_AW         = DEF_REG_AW,
  parameter int LAT_W          = DEF_LAT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hold,
  input  logic                             bubble,
  input  logic                             in_vld,
  input  logic                             in_wr,
  input  logic [REG_AW-1:0]                in_rd,
  input  logic [LAT_W-1:0]                 in_lat,
  output logic [NUM_FWD_STAGES-1:0]        ent_vld,
  output logic [NUM_FWD_STAGES-1:0]        ent_wr,
  output logic [NUM_FWD_STAGES*REG_AW-1:0] ent_rd,
  output logic [NUM_FWD_STAGES*LAT_W-1:0]  ent_cnt
);

  localparam int N = NUM_FWD_STAGES;

  logic [N-1:0]             vld_q;
  logic [N-1:0]             wr_q;
  logic [N-1:0][REG_AW-1:0] rd_q;
  logic [N-1:0][LAT_W-1:0]  cnt_q;

  function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] c);
    return (c == '0) ? '0 : c - LAT_W'(1);
  endfunction

  // Shift entries down when the pipe moves; latency counters run every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (!hold) begin
      vld_q[0] <= in_vld && !bubble;
      wr_q[0]  <= in_wr && !bubble;
      rd_q[0]  <= bubble ? '0 : in_rd;
      cnt_q[0] <= bubble ? '0 : in_lat;
      for (int k = 1; k < N; k++) begin
        vld_q[k] <= vld_q[k-1];
        wr_q[k]  <= wr_q[k-1];
        rd_q[k]  <= rd_q[k-1];
        cnt_q[k] <= sat_dec(cnt_q[k-1]);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= sat_dec(cnt_q[k]);
      end
    end
  end

  assign ent_vld = vld_q;
  assign ent_wr  = wr_q;
  assign ent_rd  = rd_q;
  assign ent_cnt = cnt_q;

  // A writer must have its result ready before it drops off the end.
  a_no_pending_drop: assert property (@(posedge clk) disable iff (rst)
    !(!hold && vld_q[N-1] && (cnt_q[N-1] != '0)));

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand/store forwarding selects and hazard stall
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_FWD_STAGES = DEF_NUM_FWD_STAGES,
  parameter int REG_AW         = DEF_REG_AW,
  parameter int LAT_W          = DEF_LAT_W,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1),
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_unit_if.slave bus
);

  localparam int N = NUM_FWD_STAGES;

  logic [N-1:0]             ent_vld;
  logic [N-1:0]             ent_wr;
  logic [N*REG_AW-1:0]      ent_rd_flat;
  logic [N*LAT_W-1:0]       ent_cnt_flat;
  logic [N-1:0][REG_AW-1:0] ent_rd;
  logic [N-1:0][LAT_W-1:0]  ent_cnt;
  logic [N-1:0]             ent_ready;
  logic [N-1:0]             match_a;
  logic [N-1:0]             match_b;
  logic [N-1:0]             match_st;

  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic [SEL_W-1:0] sel_st;
  logic             stall_a;
  logic             stall_b;
  logic             hazard_stall;
  logic [CNT_W-1:0] stall_cnt_q;

  fwd_entry_pipe #(
    .NUM_FWD_STAGES (N),
    .REG_AW         (REG_AW),
    .LAT_W          (LAT_W)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .hold    (bus.pipe_hold),
    .bubble  (hazard_stall),
    .in_vld  (bus.ex_valid),
    .in_wr   (bus.ex_regs_write),
    .in_rd   (bus.ex_rd),
    .in_lat  (bus.ex_lat),
    .ent_vld (ent_vld),
    .ent_wr  (ent_wr),
    .ent_rd  (ent_rd_flat),
    .ent_cnt (ent_cnt_flat)
  );

  assign ent_rd  = ent_rd_flat;
  assign ent_cnt = ent_cnt_flat;

  // Per-entry match terms; rd != x0 also excludes a zero source register.
  for (genvar k = 0; k < N; k++) begin : g_match
    logic writes_reg;
    assign writes_reg   = ent_vld[k] && ent_wr[k] && (ent_rd[k] != REG_AW'(REG_X0));
    assign ent_ready[k] = (ent_cnt[k] == '0);
    assign match_a[k]   = writes_reg && (ent_rd[k] == bus.ex_rs1);
    assign match_b[k]   = writes_reg && (ent_rd[k] == bus.ex_rs2);
    if (k < STORE_SRC_MIN) begin : g_no_st
      assign match_st[k] = 1'b0;
    end else begin : g_st
      assign match_st[k] = writes_reg && ent_ready[k] && (ent_rd[k] == bus.me_rs2);
    end
  end

  // Priority encode: scan oldest to youngest so the youngest match wins.
  always_comb begin
    sel_a   = SEL_W'(FWD_SEL_REG);
    sel_b   = SEL_W'(FWD_SEL_REG);
    sel_st  = SEL_W'(FWD_SEL_NONE);
    stall_a = 1'b0;
    stall_b = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        sel_a   = SEL_W'(k + 1);
        stall_a = !ent_ready[k];
      end
      if (match_b[k]) begin
        sel_b   = SEL_W'(k + 1);
        stall_b = !ent_ready[k];
      end
      if (ent_vld[0] && bus.me_mem_write && match_st[k]) begin
        sel_st = SEL_W'(k + 1);
      end
    end
  end

  assign hazard_stall = stall_a || stall_b;

  // Count cycles lost to hazards only; memory-wait freezes are not ours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hazard_stall && !bus.pipe_hold && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.fwd_sel_a     = sel_a;
  assign bus.fwd_sel_b     = sel_b;
  assign bus.fwd_sel_store = sel_st;
  assign bus.hazard_stall  = hazard_stall;
  assign bus.stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fwd_hazard_unit_if #(.REG_AW(5), .LAT_W(2), .SEL_W(2), .CNT_W(4)) bus ();

  fwd_hazard_unit #(
    .NUM_FWD_STAGES (3),
    .REG_AW         (5),
    .LAT_W          (2),
    .SEL_W          (2),
    .CNT_W          (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ex_set(input logic v, input logic w, input logic [4:0] rd,
                        input logic [1:0] lat, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.ex_valid      = v;
    bus.ex_regs_write = w;
    bus.ex_rd         = rd;
    bus.ex_lat        = lat;
    bus.ex_rs1        = rs1;
    bus.ex_rs2        = rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_set(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0);
    bus.me_mem_write = 1'b0;
    bus.me_rs2       = 5'd0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.pipe_hold = 1'b0;
    idle();

    // Reset state
    @(negedge clk);
    check_val("rst_sel_a", 32'(bus.fwd_sel_a), 0);
    check_val("rst_sel_b", 32'(bus.fwd_sel_b), 0);
    check_val("rst_sel_st", 32'(bus.fwd_sel_store), 0);
    check_val("rst_stall", 32'(bus.hazard_stall), 0);
    check_val("rst_cnt", 32'(bus.stall_cycles), 0);
    tick();
    rst = 1'b0;

    // add x5 ; add x6,x5 -> MEM forward
    ex_set(1, 1, 5'd5, 2'd0, 5'd1, 5'd2);
    tick();
    ex_set(1, 1, 5'd6, 2'd0, 5'd5, 5'd0);
    @(negedge clk);
    check_val("b2b_sel_a", 32'(bus.fwd_sel_a), 1);
    check_val("b2b_sel_b", 32'(bus.fwd_sel_b), 0);
    check_val("b2b_stall", 32'(bus.hazard_stall), 0);
    tick();
    drain();

    // add x5 ; bubble ; add x6,x5 -> WB forward
    ex_set(1, 1, 5'd5, 2'd0, 5'd0, 5'd0);
    tick();
    idle();
    tick();
    ex_set(1, 1, 5'd6, 2'd0, 5'd5, 5'd0);
    @(negedge clk);
    check_val("gap_sel_a", 32'(bus.fwd_sel_a), 2);
    tick();
    drain();

    // lw x7 ; add x8,x7,x7 -> one stall then WB forward on both operands
    ex_set(1, 1, 5'd7, 2'd1, 5'd0, 5'd0);
    tick();
    ex_set(1, 1, 5'd8, 2'd0, 5'd7, 5'd7);
    @(negedge clk);
    check_val("lu_stall", 32'(bus.hazard_stall), 1);
    check_val("lu_sel_a_stalled", 32'(bus.fwd_sel_a), 1);
    tick();
    @(negedge clk);
    check_val("lu_stall_done", 32'(bus.hazard_stall), 0);
    check_val("lu_sel_a", 32'(bus.fwd_sel_a), 2);
    check_val("lu_sel_b", 32'(bus.fwd_sel_b), 2);
    check_val("lu_cnt", 32'(bus.stall_cycles), 1);
    tick();
    drain();

    // two writes to x9 back to back, then read: youngest wins
    ex_set(1, 1, 5'd9, 2'd0, 5'd0, 5'd0);
    tick();
    tick();
    ex_set(1, 1, 5'd10, 2'd0, 5'd9, 5'd0);
    @(negedge clk);
    check_val("young_sel_a", 32'(bus.fwd_sel_a), 1);
    tick();
    drain();

    // write x0, read x0 -> no forwarding
    ex_set(1, 1, 5'd0, 2'd0, 5'd0, 5'd0);
    tick();
    ex_set(1, 1, 5'd4, 2'd0, 5'd0, 5'd0);
    @(negedge clk);
    check_val("x0_sel_a", 32'(bus.fwd_sel_a), 0);
    check_val("x0_sel_b", 32'(bus.fwd_sel_b), 0);
    check_val("x0_stall", 32'(bus.hazard_stall), 0);
    tick();
    drain();

    // lw x3 ; sw (data x3) -> store data from WB entry
    ex_set(1, 1, 5'd3, 2'd1, 5'd0, 5'd0);
    tick();
    ex_set(1, 0, 5'd0, 2'd0, 5'd2, 5'd0);
    @(negedge clk);
    check_val("st_pre_stall", 32'(bus.hazard_stall), 0);
    check_val("st_pre_sel", 32'(bus.fwd_sel_store), 0);
    tick();
    idle();
    bus.me_mem_write = 1'b1;
    bus.me_rs2       = 5'd3;
    @(negedge clk);
    check_val("st_sel", 32'(bus.fwd_sel_store), 2);
    tick();
    drain();

    // mul x12 (lat 2) ; 2 hold cycles ; dependent op -> no stall
    ex_set(1, 1, 5'd12, 2'd2, 5'd0, 5'd0);
    tick();
    idle();
    bus.pipe_hold = 1'b1;
    tick();
    tick();
    bus.pipe_hold = 1'b0;
    ex_set(1, 1, 5'd13, 2'd0, 5'd12, 5'd0);
    @(negedge clk);
    check_val("mul_stall", 32'(bus.hazard_stall), 0);
    check_val("mul_sel_a", 32'(bus.fwd_sel_a), 1);
    check_val("mul_cnt", 32'(bus.stall_cycles), 1);
    tick();
    drain();

    // async reset in the middle of a stall
    ex_set(1, 1, 5'd14, 2'd1, 5'd0, 5'd0);
    tick();
    ex_set(1, 1, 5'd15, 2'd0, 5'd14, 5'd0);
    @(negedge clk);
    check_val("mid_stall_pre", 32'(bus.hazard_stall), 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_sel_a", 32'(bus.fwd_sel_a), 0);
    check_val("mid_rst_stall", 32'(bus.hazard_stall), 0);
    check_val("mid_rst_cnt", 32'(bus.stall_cycles), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_sel_a", 32'(bus.fwd_sel_a), 0);
    tick();
    drain();

    // saturation: each lat-2 load-use costs 2 stall cycles
    for (int i = 1; i <= 9; i++) begin
      ex_set(1, 1, 5'd20, 2'd2, 5'd0, 5'd0);
      tick();
      ex_set(1, 1, 5'd21, 2'd0, 5'd20, 5'd0);
      tick();
      tick();
      @(negedge clk);
      if (i == 1) begin
        check_val("sat_sel_a_last", 32'(bus.fwd_sel_a), 3);
        check_val("sat_stall_done", 32'(bus.hazard_stall), 0);
      end
      tick();
      if (i == 7) check_val("sat_cnt14", 32'(bus.stall_cycles), 14);
      if (i == 8) check_val("sat_cnt15", 32'(bus.stall_cycles), 15);
      if (i == 9) check_val("sat_hold15", 32'(bus.stall_cycles), 15);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
